// File: rtl/prog_loader.sv
// prog_loader: assembles a big-endian byte stream into 32-bit words, writes
// them to CPU memory from word address 0, and releases the CPU when done.
module prog_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [7:0]        ByteIn,
   input  logic              ByteValid,
   output logic              ByteReady,
   output logic              MemWrEn,
   output logic [31:0]       MemWrAddr,
   output logic [31:0]       MemWrData,
   output logic              CpuRun,
   output logic              Loading,
   output logic [ADDR_W:0]   WordCount,
   output logic              Error
);

   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [31:0]     len_q, len_d;
   logic [23:0]     asm_q, asm_d;
   logic            byte_ready_q, byte_ready_d;
   logic            mem_wr_en_q, mem_wr_en_d;
   logic [31:0]     mem_wr_addr_q, mem_wr_addr_d;
   logic [31:0]     mem_wr_data_q, mem_wr_data_d;
   logic            cpu_run_q, cpu_run_d;
   logic            loading_q, loading_d;
   logic [CW-1:0]   word_count_q, word_count_d;
   logic            error_q, error_d;

   logic            accept;
   logic [31:0]     hdr_len;
   logic [31:0]     word;

   // A byte moves only when the loader advertised ready in this cycle
   assign accept = ByteValid && byte_ready_q;

   assign ByteReady = byte_ready_q;
   assign MemWrEn   = mem_wr_en_q;
   assign MemWrAddr = mem_wr_addr_q;
   assign MemWrData = mem_wr_data_q;
   assign CpuRun    = cpu_run_q;
   assign Loading   = loading_q;
   assign WordCount = word_count_q;
   assign Error     = error_q;

   // Next-state and next-output computation
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      len_d         = len_q;
      asm_d         = asm_q;
      byte_ready_d  = byte_ready_q;
      mem_wr_en_d   = 1'b0;
      mem_wr_addr_d = mem_wr_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      cpu_run_d     = cpu_run_q;
      loading_d     = loading_q;
      word_count_d  = word_count_q;
      error_d       = error_q;
      hdr_len       = {len_q[23:0], ByteIn};
      word          = {asm_q, ByteIn};

      unique case (state_q)
         S_IDLE: begin
            byte_ready_d = 1'b0;
            loading_d    = 1'b0;
         end

         S_HEADER: begin
            if (accept) begin
               len_d = hdr_len;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (hdr_len == 32'd0) begin
                     state_d      = S_DONE;
                     byte_ready_d = 1'b0;
                     loading_d    = 1'b0;
                     cpu_run_d    = 1'b1;
                  end else if (hdr_len > 32'(DEPTH)) begin
                     state_d      = S_ERR;
                     byte_ready_d = 1'b0;
                     loading_d    = 1'b0;
                     error_d      = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end

         S_LOAD: begin
            if (accept) begin
               asm_d = word[23:0];
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  mem_wr_en_d   = 1'b1;
                  mem_wr_addr_d = 32'(word_count_q);
                  mem_wr_data_d = word;
                  word_count_d  = word_count_q + CW'(1);
                  // Last word: the write cycle is spent in DONE, outputs settle after
                  if (32'(word_count_q) + 32'd1 == len_q) begin
                     state_d = S_DONE;
                  end
               end
            end
         end

         S_DONE: begin
            byte_ready_d = 1'b0;
            loading_d    = 1'b0;
            cpu_run_d    = 1'b1;
         end

         S_ERR: begin
            byte_ready_d = 1'b0;
            loading_d    = 1'b0;
            cpu_run_d    = 1'b0;
            error_d      = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Start opens a new session from any idle-like state; ignored mid-load
      if (Start && (state_q inside {S_IDLE, S_DONE, S_ERR})) begin
         state_d      = S_HEADER;
         idx_d        = 2'd0;
         len_d        = 32'd0;
         word_count_d = '0;
         error_d      = 1'b0;
         cpu_run_d    = 1'b0;
         byte_ready_d = 1'b1;
         loading_d    = 1'b1;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         idx_q         <= 2'd0;
         len_q         <= 32'd0;
         asm_q         <= 24'd0;
         byte_ready_q  <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_addr_q <= 32'd0;
         mem_wr_data_q <= 32'd0;
         cpu_run_q     <= 1'b0;
         loading_q     <= 1'b0;
         word_count_q  <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         asm_q         <= asm_d;
         byte_ready_q  <= byte_ready_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_addr_q <= mem_wr_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         cpu_run_q     <= cpu_run_d;
         loading_q     <= loading_d;
         word_count_q  <= word_count_d;
         error_q       <= error_d;
      end
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the single-cycle CPU datapath and its unified instruction/data memory.
- Before execution starts, it takes a byte stream from a host link and assembles it into 32-bit big-endian words.
- Each word is written into memory at consecutive word addresses starting at 0. The CPU PC also starts at 0 and increments by 1 per instruction.
- The CPU is held off until the program is complete: it runs only while CpuRun=1.

Parameters:
- ADDR_W, 8, memory word-address width. Memory depth DEPTH = 2**ADDR_W words.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a load session.
- ByteIn  in  8  incoming program byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle. A transfer occurs when ByteValid && ByteReady at the clock edge.
- MemWrEn  out  1  one-cycle memory write strobe.
- MemWrAddr  out  32  word address, zero-extended from the word index.
- MemWrData  out  32  assembled word.
- CpuRun  out  1  1 = CPU may execute; 0 = CPU held at PC 0.
- Loading  out  1  1 while in HEADER or LOAD.
- WordCount  out  ADDR_W+1  number of words written in the current session.
- Error  out  1  header length exceeded DEPTH.

Behaviour:
- Reset values (after any cycle with Reset=1):
  - State is IDLE.
  - ByteReady, MemWrEn, CpuRun, Loading and Error are 0.
  - MemWrAddr, MemWrData and WordCount are 0.
  - Byte index and length register are 0.
- Reset has priority over every other input.
- Reset mid-session aborts immediately. Words already written stay in memory; no further writes occur.
- States: IDLE, HEADER, LOAD, DONE, ERR. All outputs are registered.
- IDLE:
  - ByteReady=0.
  - Start=1 -> go to HEADER. Clear byte index, WordCount and Error; set CpuRun=0.
- HEADER:
  - ByteReady=1, Loading=1.
  - Accept 4 bytes, MSB first, into the 32-bit length L.
  - On the 4th accepted byte:
    - L=0 -> DONE.
    - L>DEPTH -> ERR.
    - otherwise -> LOAD.
- LOAD:
  - ByteReady=1, Loading=1.
  - Bytes are shifted MSB-first into the assembly register; the byte index wraps 3->0.
  - On the 4th byte of a word, the next cycle has:
    - MemWrEn=1 for exactly one cycle,
    - MemWrAddr = WordCount (pre-increment value),
    - MemWrData = the assembled word.
  - WordCount increments in that same cycle.
  - Write latency is 1 cycle from the 4th byte's accepting edge.
  - ByteReady stays 1 during the write cycle; there is no stall. A byte accepted in the write cycle goes into the next word.
  - When the written word is number L, go to DONE in the write cycle. ByteReady=0 from the following cycle.
- DONE:
  - CpuRun=1, ByteReady=0, Loading=0. WordCount holds.
  - Start=1 -> go to HEADER with CpuRun=0 (reload).
- ERR:
  - Error=1, CpuRun=0, ByteReady=0.
  - Start=1 -> go to HEADER with Error cleared.
- Start while in HEADER or LOAD is ignored.
- ByteValid while ByteReady=0 is ignored; no byte is consumed.
- Gaps in ByteValid are permitted at any point. Partial-word state holds indefinitely; there is no timeout.
- L=DEPTH is legal. The last write goes to address DEPTH-1 and WordCount reaches DEPTH, which needs an ADDR_W+1-bit field.
- MemWrEn is never asserted outside the LOAD/DONE-entry write cycle.

Test Plan:
1. Reset=1 for 2 cycles with Start=1 and ByteValid=1 -> all outputs 0, state IDLE, no write.
2. Start; header 00 00 00 02; data 12 34 56 78 9A BC DE F0 streamed back-to-back ->
   - write addr 0 = 0x12345678, one cycle after byte 0x78;
   - write addr 1 = 0x9ABCDEF0;
   - exactly 2 MemWrEn pulses; CpuRun=1, WordCount=2, ByteReady=0 afterwards.
3. Start; header 00 00 00 00 -> DONE immediately after the 4th header byte, zero writes, CpuRun=1, WordCount=0.
4. ADDR_W=8; header 00 00 01 01 (L=257) -> Error=1, ByteReady=0, CpuRun=0. Then Start; header 00 00 00 01; data DE AD BE EF -> Error=0, write addr 0 = 0xDEADBEEF, CpuRun=1.
5. Same stream as test 2, with ByteValid low for 3 cycles between every byte and Start pulsed during LOAD -> identical writes and final state; Start has no effect.
6. Start; header 00 00 00 02; bytes 11 22 33 44 55 66; Reset for 1 cycle -> only addr 0 = 0x11223344 written; IDLE; CpuRun=0. Then Start with header 00 00 00 01 and data 01 02 03 04 -> addr 0 = 0x01020304, WordCount=1.
